// File: rtl/card_dispatch_arbiter.sv
// card_dispatch_arbiter
//
// Shares one card deck between the player and dealer hand controllers.
// It runs the opening four-card deal (player, dealer, player, dealer) when
// i_newRound arrives, and otherwise serves single-card hit requests. When
// both hands ask at once, they take turns. Each card is fetched with one
// draw strobe. The deck answers DECK_LATENCY cycles later. The card is
// registered and then handed to exactly one hand with a one-cycle load pulse.
//
// Handshake: i_playerReq / i_dealerReq are levels. They are looked at only
// while the arbiter is idle. A requester drops its level on the edge where
// it sees its load pulse; a level still high after that counts as a new
// request. o_deckDraw is a one-cycle strobe, and i_deckCard must be valid
// exactly DECK_LATENCY cycles later. o_card is valid while o_playerLoad or
// o_dealerLoad is high, and holds its value otherwise.
//
// Ports:
//   i_clk, i_reset     clock (rising edge), asynchronous active-high reset
//   i_newRound         pulse, start the opening deal (ignored unless idle)
//   i_playerReq        level, player wants a card
//   i_dealerReq        level, dealer wants a card
//   o_deckDraw         draw strobe to the deck
//   i_deckCard         card from the deck
//   o_card             registered card for the hand being loaded
//   o_playerLoad       player hand adds o_card
//   o_dealerLoad       dealer hand adds o_card
//   o_busy             high whenever the FSM is not idle
//   o_dealDone         pulses with the fourth opening-deal load
//   o_lastGrant        0 = last card went to player, 1 = to dealer
module card_dispatch_arbiter #(
  parameter int DECK_LATENCY = 1,
  parameter int CARD_W       = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_newRound,
  input  logic              i_playerReq,
  input  logic              i_dealerReq,
  output logic              o_deckDraw,
  input  logic [CARD_W-1:0] i_deckCard,
  output logic [CARD_W-1:0] o_card,
  output logic              o_playerLoad,
  output logic              o_dealerLoad,
  output logic              o_busy,
  output logic              o_dealDone,
  output logic              o_lastGrant
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  // The wait counter counts down to zero. The card is captured on the
  // cycle the counter reads zero, so the counter starts at DECK_LATENCY-1.
  localparam logic [2:0] WAIT_LOAD = 3'(DECK_LATENCY - 1);

  logic [1:0] state;
  logic [2:0] waitCnt;
  logic       dealMode;
  logic [1:0] dealIdx;
  logic       target;    // 0 = player, 1 = dealer

  // Every output is a flop. Each output is set on the edge that enters the
  // state it belongs to, so each pulse lines up with its state cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      waitCnt      <= '0;
      dealMode     <= 1'b0;
      dealIdx      <= 2'd0;
      target       <= 1'b0;
      o_deckDraw   <= 1'b0;
      o_card       <= '0;
      o_playerLoad <= 1'b0;
      o_dealerLoad <= 1'b0;
      o_busy       <= 1'b0;
      o_dealDone   <= 1'b0;
      o_lastGrant  <= 1'b1;
    end else begin
      o_deckDraw   <= 1'b0;
      o_playerLoad <= 1'b0;
      o_dealerLoad <= 1'b0;
      o_dealDone   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_newRound) begin
            dealMode   <= 1'b1;
            dealIdx    <= 2'd0;
            target     <= 1'b0;
            state      <= S_ISSUE;
            o_deckDraw <= 1'b1;
            o_busy     <= 1'b1;
          end else if (i_playerReq || i_dealerReq) begin
            // On a tie, the side that did not get the last card wins.
            // With only one requester, i_dealerReq alone names the target.
            target     <= (i_playerReq && i_dealerReq) ? ~o_lastGrant : i_dealerReq;
            state      <= S_ISSUE;
            o_deckDraw <= 1'b1;
            o_busy     <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          waitCnt <= WAIT_LOAD;
          o_busy  <= 1'b1;
        end
        S_WAIT: begin
          o_busy <= 1'b1;
          if (waitCnt == 3'd0) begin
            o_card       <= i_deckCard;
            state        <= S_DELIVER;
            o_playerLoad <= ~target;
            o_dealerLoad <= target;
            o_lastGrant  <= target;
            o_dealDone   <= dealMode && (dealIdx == 2'd3);
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        S_DELIVER: begin
          if (dealMode && (dealIdx != 2'd3)) begin
            // Deal order alternates player/dealer, so bit 0 of the next
            // index names the next target.
            dealIdx    <= dealIdx + 2'd1;
            target     <= ~dealIdx[0];
            state      <= S_ISSUE;
            o_deckDraw <= 1'b1;
            o_busy     <= 1'b1;
          end else begin
            dealMode <= 1'b0;
            dealIdx  <= 2'd0;
            state    <= S_IDLE;
            o_busy   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dispatch_arbiter.sv
module tb_card_dispatch_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT with DECK_LATENCY = 1
  logic       nr1 = 0, pr1 = 0, dr1 = 0;
  logic [5:0] deck1 = 6'h3F;
  logic       draw1, pl1, dl1, busy1, dd1, lg1;
  logic [5:0] card1;

  // DUT with DECK_LATENCY = 4
  logic       nr4 = 0, pr4 = 0, dr4 = 0;
  logic [5:0] deck4 = 6'h3F;
  logic       draw4, pl4, dl4, busy4, dd4, lg4;
  logic [5:0] card4;

  card_dispatch_arbiter #(.DECK_LATENCY(1), .CARD_W(6)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_newRound(nr1), .i_playerReq(pr1),
    .i_dealerReq(dr1), .o_deckDraw(draw1), .i_deckCard(deck1), .o_card(card1),
    .o_playerLoad(pl1), .o_dealerLoad(dl1), .o_busy(busy1),
    .o_dealDone(dd1), .o_lastGrant(lg1)
  );

  card_dispatch_arbiter #(.DECK_LATENCY(4), .CARD_W(6)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_newRound(nr4), .i_playerReq(pr4),
    .i_dealerReq(dr4), .o_deckDraw(draw4), .i_deckCard(deck4), .o_card(card4),
    .o_playerLoad(pl4), .o_dealerLoad(dl4), .o_busy(busy4),
    .o_dealDone(dd4), .o_lastGrant(lg4)
  );

  // Deck model for dut1: the cycle after a draw, present the next card.
  // Otherwise present 0x3F, which no test card uses.
  logic [5:0] deck_q[$];
  logic       draw_seen1 = 1'b0;
  always @(negedge clk) draw_seen1 = draw1;
  always @(posedge clk) begin
    #1;
    if (draw_seen1 && deck_q.size() > 0) deck1 = deck_q.pop_front();
    else deck1 = 6'h3F;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (draw1 !== 1'b0) begin errors++; $display("FAIL reset_draw got %b want 0", draw1); end
    checks++; if (pl1 !== 1'b0 || dl1 !== 1'b0) begin errors++; $display("FAIL reset_load got %b%b want 00", pl1, dl1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (dd1 !== 1'b0) begin errors++; $display("FAIL reset_dealdone got %b want 0", dd1); end
    checks++; if (card1 !== 6'h00) begin errors++; $display("FAIL reset_card got %h want 00", card1); end
    checks++; if (lg1 !== 1'b1) begin errors++; $display("FAIL reset_lastgrant got %b want 1", lg1); end
    checks++; if (busy4 !== 1'b0 || lg4 !== 1'b1) begin errors++; $display("FAIL reset_dut4 busy=%b lg=%b want 0/1", busy4, lg4); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Full opening deal on dut1, i_newRound in relative cycle 0.
  task automatic run_deal(input logic [5:0] c0, input logic [5:0] c1,
                          input logic [5:0] c2, input logic [5:0] c3, input string tag);
    logic exp_draw, exp_pl, exp_dl, exp_dd, exp_busy;
    logic [5:0] exp_card;
    deck_q = {c0, c1, c2, c3};
    nr1 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      exp_draw = (k == 1 || k == 4 || k == 7 || k == 10);
      exp_pl   = (k == 3 || k == 9);
      exp_dl   = (k == 6 || k == 12);
      exp_dd   = (k == 12);
      exp_busy = (k >= 1 && k <= 12);
      exp_card = (k == 3) ? c0 : (k == 6) ? c1 : (k == 9) ? c2 : c3;
      @(negedge clk);
      checks++; if (draw1 !== exp_draw) begin errors++; $display("FAIL %s_draw cyc %0d got %b want %b", tag, k, draw1, exp_draw); end
      checks++; if (pl1 !== exp_pl) begin errors++; $display("FAIL %s_pload cyc %0d got %b want %b", tag, k, pl1, exp_pl); end
      checks++; if (dl1 !== exp_dl) begin errors++; $display("FAIL %s_dload cyc %0d got %b want %b", tag, k, dl1, exp_dl); end
      checks++; if (dd1 !== exp_dd) begin errors++; $display("FAIL %s_dealdone cyc %0d got %b want %b", tag, k, dd1, exp_dd); end
      checks++; if (busy1 !== exp_busy) begin errors++; $display("FAIL %s_busy cyc %0d got %b want %b", tag, k, busy1, exp_busy); end
      if (exp_pl || exp_dl) begin
        checks++; if (card1 !== exp_card) begin errors++; $display("FAIL %s_card cyc %0d got %h want %h", tag, k, card1, exp_card); end
      end
      if (k == 13) begin
        checks++; if (lg1 !== 1'b1) begin errors++; $display("FAIL %s_lastgrant got %b want 1", tag, lg1); end
      end
      @(posedge clk); #1;
      nr1 = 1'b0;
    end
  endtask

  task automatic test_deal();
    run_deal(6'h05, 6'h0A, 6'h11, 6'h23, "deal");
  endtask

  task automatic test_hit_player();
    deck_q = {6'h15};
    pr1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (draw1 !== (k == 1)) begin errors++; $display("FAIL hitp_draw cyc %0d got %b want %b", k, draw1, (k == 1)); end
      checks++; if (pl1 !== (k == 3) || dl1 !== 1'b0) begin errors++; $display("FAIL hitp_load cyc %0d got p%b d%b want p%b d0", k, pl1, dl1, (k == 3)); end
      checks++; if (busy1 !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL hitp_busy cyc %0d got %b want %b", k, busy1, (k >= 1 && k <= 3)); end
      if (k == 3) begin
        checks++; if (card1 !== 6'h15) begin errors++; $display("FAIL hitp_card got %h want 15", card1); end
        checks++; if (lg1 !== 1'b0) begin errors++; $display("FAIL hitp_lastgrant got %b want 0", lg1); end
      end
      @(posedge clk); #1;
      pr1 = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    deck_q = {6'h2A, 6'h33};
    pr1 = 1'b1; dr1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++; if (draw1 !== (k == 1 || k == 5)) begin errors++; $display("FAIL rr_draw cyc %0d got %b want %b", k, draw1, (k == 1 || k == 5)); end
      checks++; if (dl1 !== (k == 3)) begin errors++; $display("FAIL rr_dload cyc %0d got %b want %b", k, dl1, (k == 3)); end
      checks++; if (pl1 !== (k == 7)) begin errors++; $display("FAIL rr_pload cyc %0d got %b want %b", k, pl1, (k == 7)); end
      if (k == 3) begin
        checks++; if (card1 !== 6'h2A || lg1 !== 1'b1) begin errors++; $display("FAIL rr_first card=%h lg=%b want 2a/1", card1, lg1); end
      end
      if (k == 7) begin
        checks++; if (card1 !== 6'h33 || lg1 !== 1'b0) begin errors++; $display("FAIL rr_second card=%h lg=%b want 33/0", card1, lg1); end
      end
      @(posedge clk); #1;
      if (k == 7) begin pr1 = 1'b0; dr1 = 1'b0; end
    end
  endtask

  task automatic test_newround_ignored();
    deck_q = {6'h07};
    pr1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++; if (draw1 !== (k == 1)) begin errors++; $display("FAIL nrign_draw cyc %0d got %b want %b", k, draw1, (k == 1)); end
      checks++; if (pl1 !== (k == 3)) begin errors++; $display("FAIL nrign_pload cyc %0d got %b want %b", k, pl1, (k == 3)); end
      checks++; if (dd1 !== 1'b0) begin errors++; $display("FAIL nrign_dealdone cyc %0d got %b want 0", k, dd1); end
      checks++; if (busy1 !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL nrign_busy cyc %0d got %b want %b", k, busy1, (k >= 1 && k <= 3)); end
      if (k == 3) begin
        checks++; if (card1 !== 6'h07) begin errors++; $display("FAIL nrign_card got %h want 07", card1); end
      end
      @(posedge clk); #1;
      pr1 = 1'b0;
      nr1 = (k == 1);   // i_newRound high during relative cycle 2 (WAIT)
    end
  endtask

  task automatic test_latency4();
    dr4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      deck4 = (k == 4) ? 6'h1C : (k == 5) ? 6'h2E : 6'h3F;
      @(negedge clk);
      checks++; if (draw4 !== (k == 1)) begin errors++; $display("FAIL lat4_draw cyc %0d got %b want %b", k, draw4, (k == 1)); end
      checks++; if (dl4 !== (k == 6) || pl4 !== 1'b0) begin errors++; $display("FAIL lat4_load cyc %0d got d%b p%b want d%b p0", k, dl4, pl4, (k == 6)); end
      checks++; if (busy4 !== (k >= 1 && k <= 6)) begin errors++; $display("FAIL lat4_busy cyc %0d got %b want %b", k, busy4, (k >= 1 && k <= 6)); end
      if (k >= 6) begin
        checks++; if (card4 !== 6'h2E) begin errors++; $display("FAIL lat4_card cyc %0d got %h want 2e", k, card4); end
      end
      @(posedge clk); #1;
      dr4 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    deck_q = {6'h09, 6'h0B, 6'h0D, 6'h0F};
    nr1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) rst = 1'b1;    // relative cycle 8 is the third deal WAIT
      if (k == 10) rst = 1'b0;
      @(negedge clk);
      checks++; if (draw1 !== (k == 1 || k == 4 || k == 7)) begin errors++; $display("FAIL rmid_draw cyc %0d got %b want %b", k, draw1, (k == 1 || k == 4 || k == 7)); end
      checks++; if (pl1 !== (k == 3) || dl1 !== (k == 6)) begin errors++; $display("FAIL rmid_load cyc %0d got p%b d%b want p%b d%b", k, pl1, dl1, (k == 3), (k == 6)); end
      checks++; if (busy1 !== (k >= 1 && k <= 7)) begin errors++; $display("FAIL rmid_busy cyc %0d got %b want %b", k, busy1, (k >= 1 && k <= 7)); end
      if (k == 8) begin
        checks++; if (lg1 !== 1'b1 || dd1 !== 1'b0 || card1 !== 6'h00) begin errors++; $display("FAIL rmid_regs lg=%b dd=%b card=%h want 1/0/00", lg1, dd1, card1); end
      end
      @(posedge clk); #1;
      nr1 = 1'b0;
    end
    deck_q.delete();
    run_deal(6'h01, 6'h02, 6'h03, 6'h04, "restart");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_deal();
    test_hit_player();
    test_round_robin();
    test_newround_ignored();
    test_latency4();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_dispatch_arbiter.md
# card_dispatch_arbiter

Sequences the single shared card deck between the player and dealer hand controllers. It owns the deck's draw strobe, runs the opening four-card deal, and arbitrates later hit requests. Each card is delivered to exactly one hand as a registered one-cycle load pulse, so a draw and its hand update never happen in the same cycle. It sits between the game FSM and hand controllers on one side and the card deck on the other.

## Interface
Parameters:
- DECK_LATENCY, 1: cycles from o_deckDraw pulse until i_deckCard is valid; legal range 1–7.
- CARD_W, 6: width of the card encoding.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_newRound  in  1  one-cycle pulse; starts the opening deal.
- i_playerReq  in  1  level; player hand wants one card.
- i_dealerReq  in  1  level; dealer hand wants one card.
- o_deckDraw  out  1  one-cycle draw strobe to deck.
- i_deckCard  in  CARD_W  card from deck; valid DECK_LATENCY cycles after strobe.
- o_card  out  CARD_W  registered card; valid while a load pulse is high.
- o_playerLoad  out  1  one-cycle pulse; player hand adds o_card.
- o_dealerLoad  out  1  one-cycle pulse; dealer hand adds o_card.
- o_busy  out  1  high in every state except IDLE.
- o_dealDone  out  1  one-cycle pulse with the fourth opening-deal load.
- o_lastGrant  out  1  0 = last card went to player, 1 = to dealer.

## Operation
- States:
  - IDLE: samples inputs and picks the next action.
  - ISSUE: o_deckDraw = 1 for this one cycle.
  - WAIT: lasts DECK_LATENCY cycles; on its last cycle, i_deckCard is captured into the card register.
  - DELIVER: the load pulse for the target hand is high.
- Priority in IDLE:
  - i_newRound first: enter deal mode, deal index = 0, go to ISSUE.
  - Otherwise, one request alone: target that requester, go to ISSUE.
  - Both requests: grant the side opposite o_lastGrant (round robin).
  - No request: stay in IDLE.
- Deal mode order: player, dealer, player, dealer (index 0–3, 2-bit counter).
  - DELIVER with index < 3: increment index, go straight to ISSUE.
  - DELIVER with index 3: pulse o_dealDone, clear deal mode, go to IDLE.
  - i_playerReq and i_dealerReq are ignored during deal mode.
- Hit mode: DELIVER always returns to IDLE.
- o_lastGrant updates in every DELIVER cycle, including deal mode.
- Requests are sampled only in IDLE. A requester must drop its request on the edge where it sees its load pulse. A request held longer is treated as a new request.
- i_newRound outside IDLE is ignored, with no queuing.
- Only one draw is ever outstanding; o_deckDraw never pulses twice without a DELIVER between.
- o_card holds its last value between deliveries. o_playerLoad and o_dealerLoad are never high together.
- Reset values:
  - State IDLE; o_deckDraw, o_playerLoad, o_dealerLoad, o_busy, o_dealDone = 0.
  - o_card = 0; o_lastGrant = 1, so the player wins the first tie.
  - Deal index 0; deal mode cleared.
- Reset mid-operation: any in-flight card is discarded, no load pulse is emitted, and the FSM returns to IDLE immediately.

## Timing
- Request seen in IDLE at cycle n:
  - o_deckDraw at n+1.
  - Card captured at n+1+DECK_LATENCY.
  - Load pulse at n+2+DECK_LATENCY.
  - IDLE at n+3+DECK_LATENCY.
- Per-card cost: 2+DECK_LATENCY cycles in deal mode, plus 1 IDLE cycle in hit mode.
- Opening deal with DECK_LATENCY=1 and i_newRound at cycle 0:
  - o_deckDraw at 1, 4, 7, 10.
  - Loads at 3 (P), 6 (D), 9 (P), 12 (D).
  - o_dealDone at 12; IDLE at 13.
- All outputs are registered; no input-to-output combinational path.

## Test plan
- Reset, then drive i_newRound at cycle 0 with deck cards 0x05, 0x0A, 0x11, 0x23 (DECK_LATENCY=1) -> o_playerLoad at 3 with 0x05 and at 9 with 0x11; o_dealerLoad at 6 with 0x0A and at 12 with 0x23; o_dealDone only at 12; o_busy high for cycles 1–12.
- After the deal, hold i_playerReq high alone for one IDLE cycle (cycle n) -> o_deckDraw at n+1, o_playerLoad at n+3, o_lastGrant = 0.
- i_playerReq and i_dealerReq both asserted in IDLE with o_lastGrant = 0 -> dealer served first. If both stay asserted after the dealer's load, the next card goes to the player.
- DECK_LATENCY=4, single dealer request at cycle n -> o_deckDraw at n+1, o_dealerLoad at n+6; i_deckCard is sampled only at n+5 (a different value presented at n+4 must not appear on o_card).
- Pulse i_newRound while a hit is in WAIT -> ignored: hit completes normally, no extra o_deckDraw, no o_dealDone.
- Assert i_reset during the third deal WAIT -> o_busy = 0 and all pulses 0 immediately; no load for that card; o_lastGrant = 1; a later i_newRound restarts the deal from player index 0.
